// File: rtl/branch_resolver_pkg.sv
// Shared types and sizes for the branch resolver: completion packet layout,
// branch-mask width and a lowest-set-bit helper used by slot selection.
package branch_resolver_pkg;

  localparam int NUM_BR_FU    = 2;
  localparam int B_MASK_WIDTH = 4;
  localparam int ADDR_WIDTH   = 32;

  typedef logic [B_MASK_WIDTH-1:0] b_mask_t;
  typedef logic [ADDR_WIDTH-1:0]   addr_t;

  typedef struct packed {
    logic    valid;
    b_mask_t b_mm;
    b_mask_t b_mask;
    logic    mispred;
    addr_t   target;
  } br_cmpl_packet_t;

  // Isolates the lowest set bit (the oldest-index slot) of a mask.
  function automatic b_mask_t lowest_set(input b_mask_t v);
    return v & (~v + b_mask_t'(1));
  endfunction

endpackage

// File: rtl/br_resolve_select.sv
// Picks the one slot to broadcast: lowest eligible mispredict first, else the
// lowest valid correct entry not waiting on any pending mispredict.
module br_resolve_select
  import branch_resolver_pkg::*;
(
  input  logic [B_MASK_WIDTH-1:0]                   i_valid,
  input  logic [B_MASK_WIDTH-1:0]                   i_mispred,
  input  logic [B_MASK_WIDTH-1:0][B_MASK_WIDTH-1:0] i_dep,
  output logic [B_MASK_WIDTH-1:0]                   o_grant,
  output logic                                      o_mispred
);

  logic [B_MASK_WIDTH-1:0] w_pend_mp;
  logic [B_MASK_WIDTH-1:0] w_clear;
  logic [B_MASK_WIDTH-1:0] w_elig_mp;
  logic [B_MASK_WIDTH-1:0] w_elig_ok;

  assign w_pend_mp = i_valid & i_mispred;

  // An entry may go only if none of the branches it depends on is a pending mispredict.
  for (genvar gi = 0; gi < B_MASK_WIDTH; gi++) begin : g_clear
    assign w_clear[gi] = ((i_dep[gi] & w_pend_mp) == '0);
  end

  assign w_elig_mp = w_pend_mp & w_clear;
  assign w_elig_ok = i_valid & ~i_mispred & w_clear;

  always_comb begin
    o_grant   = '0;
    o_mispred = 1'b0;
    if (w_elig_mp != '0) begin
      o_grant   = lowest_set(w_elig_mp);
      o_mispred = 1'b1;
    end else begin
      o_grant   = lowest_set(w_elig_ok);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Collects branch completions into a per-slot pending table and broadcasts
// one resolve per cycle, squashing or un-tagging dependents of the broadcast branch.
module branch_resolver
  import branch_resolver_pkg::*;
(
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  input  logic [NUM_BR_FU-1:0]                   i_br_cmpl_valid,
  input  logic [NUM_BR_FU-1:0][B_MASK_WIDTH-1:0] i_br_cmpl_b_mm,
  input  logic [NUM_BR_FU-1:0][B_MASK_WIDTH-1:0] i_br_cmpl_b_mask,
  input  logic [NUM_BR_FU-1:0]                   i_br_cmpl_mispred,
  input  logic [NUM_BR_FU-1:0][ADDR_WIDTH-1:0]   i_br_cmpl_target,
  output logic [B_MASK_WIDTH-1:0]                o_b_mm_resolve,
  output logic                                   o_b_mm_mispred,
  output logic [ADDR_WIDTH-1:0]                  o_b_mm_target,
  output logic [B_MASK_WIDTH-1:0]                o_pending_mask
);

  br_cmpl_packet_t w_pkt [NUM_BR_FU];

  logic [B_MASK_WIDTH-1:0]                   r_valid;
  logic [B_MASK_WIDTH-1:0]                   r_mispred;
  logic [B_MASK_WIDTH-1:0][B_MASK_WIDTH-1:0] r_dep;
  logic [B_MASK_WIDTH-1:0][ADDR_WIDTH-1:0]   r_target;
  logic [B_MASK_WIDTH-1:0]                   r_resolve;
  logic                                      r_resolve_mp;
  logic [ADDR_WIDTH-1:0]                     r_resolve_tgt;

  logic [B_MASK_WIDTH-1:0]                   w_kill_bits;
  logic [B_MASK_WIDTH-1:0]                   w_nxt_valid;
  logic [B_MASK_WIDTH-1:0]                   w_nxt_mp;
  logic [B_MASK_WIDTH-1:0][B_MASK_WIDTH-1:0] w_nxt_dep;
  logic [B_MASK_WIDTH-1:0][ADDR_WIDTH-1:0]   w_nxt_tgt;
  logic [B_MASK_WIDTH-1:0]                   w_grant;
  logic                                      w_grant_mp;
  logic [ADDR_WIDTH-1:0]                     w_grant_tgt;

  for (genvar gi = 0; gi < NUM_BR_FU; gi++) begin : g_pkt
    assign w_pkt[gi].valid   = i_br_cmpl_valid[gi];
    assign w_pkt[gi].b_mm    = i_br_cmpl_b_mm[gi];
    assign w_pkt[gi].b_mask  = i_br_cmpl_b_mask[gi];
    assign w_pkt[gi].mispred = i_br_cmpl_mispred[gi];
    assign w_pkt[gi].target  = i_br_cmpl_target[gi];
  end

  // Dependents of the mispredict currently on the bus are squashed.
  assign w_kill_bits = r_resolve & {B_MASK_WIDTH{r_resolve_mp}};

  // Table as it would stand after this edge, before removing the new grant.
  always_comb begin
    w_nxt_valid = '0;
    w_nxt_mp    = '0;
    w_nxt_dep   = '0;
    w_nxt_tgt   = '0;
    for (int s = 0; s < B_MASK_WIDTH; s++) begin
      if (r_valid[s] && ((r_dep[s] & w_kill_bits) == '0)) begin
        w_nxt_valid[s] = 1'b1;
        w_nxt_mp[s]    = r_mispred[s];
        w_nxt_dep[s]   = r_dep[s] & ~r_resolve;
        w_nxt_tgt[s]   = r_target[s];
      end
      for (int p = 0; p < NUM_BR_FU; p++) begin
        if (w_pkt[p].valid && w_pkt[p].b_mm[s] &&
            ((w_pkt[p].b_mask & w_kill_bits) == '0)) begin
          w_nxt_valid[s] = 1'b1;
          w_nxt_mp[s]    = w_pkt[p].mispred;
          w_nxt_dep[s]   = w_pkt[p].b_mask & ~r_resolve;
          w_nxt_tgt[s]   = w_pkt[p].target;
        end
      end
    end
  end

  br_resolve_select u_select (
    .i_valid   (w_nxt_valid),
    .i_mispred (w_nxt_mp),
    .i_dep     (w_nxt_dep),
    .o_grant   (w_grant),
    .o_mispred (w_grant_mp)
  );

  always_comb begin
    w_grant_tgt = '0;
    for (int s = 0; s < B_MASK_WIDTH; s++) begin
      if (w_grant[s]) w_grant_tgt = w_grant_tgt | w_nxt_tgt[s];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid       <= '0;
      r_mispred     <= '0;
      r_dep         <= '0;
      r_target      <= '0;
      r_resolve     <= '0;
      r_resolve_mp  <= 1'b0;
      r_resolve_tgt <= '0;
    end else begin
      r_valid       <= w_nxt_valid & ~w_grant;
      r_mispred     <= w_nxt_mp;
      r_dep         <= w_nxt_dep;
      r_target      <= w_nxt_tgt;
      r_resolve     <= w_grant;
      r_resolve_mp  <= w_grant_mp;
      r_resolve_tgt <= w_grant_tgt;
    end
  end

  // Arrivals must be one-hot and must not collide with a held or broadcasting slot.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int p = 0; p < NUM_BR_FU; p++) begin
        if (i_br_cmpl_valid[p]) begin
          assert ($onehot(i_br_cmpl_b_mm[p]));
          assert ((i_br_cmpl_b_mm[p] & r_resolve) == '0);
          assert ((i_br_cmpl_b_mm[p] & r_valid) == '0);
        end
      end
    end
  end

  assign o_b_mm_resolve = r_resolve;
  assign o_b_mm_mispred = r_resolve_mp;
  assign o_b_mm_target  = r_resolve_tgt;
  assign o_pending_mask = r_valid;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench: each cycle's expected broadcast is queued as stimulus is
// driven and compared after the following clock edge.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic                                   clk = 1'b0;
  logic                                   rst;
  logic [NUM_BR_FU-1:0]                   v;
  logic [NUM_BR_FU-1:0][B_MASK_WIDTH-1:0] bmm;
  logic [NUM_BR_FU-1:0][B_MASK_WIDTH-1:0] bmask;
  logic [NUM_BR_FU-1:0]                   mp;
  logic [NUM_BR_FU-1:0][ADDR_WIDTH-1:0]   tgt;
  logic [B_MASK_WIDTH-1:0]                o_res;
  logic                                   o_mp;
  logic [ADDR_WIDTH-1:0]                  o_tgt;
  logic [B_MASK_WIDTH-1:0]                o_pend;

  typedef struct {
    string                   tag;
    logic [B_MASK_WIDTH-1:0] res;
    logic                    mp;
    logic [ADDR_WIDTH-1:0]   tgt;
    logic [B_MASK_WIDTH-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_resolver dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_br_cmpl_valid   (v),
    .i_br_cmpl_b_mm    (bmm),
    .i_br_cmpl_b_mask  (bmask),
    .i_br_cmpl_mispred (mp),
    .i_br_cmpl_target  (tgt),
    .o_b_mm_resolve    (o_res),
    .o_b_mm_mispred    (o_mp),
    .o_b_mm_target     (o_tgt),
    .o_pending_mask    (o_pend)
  );

  task automatic clear_in();
    v = '0; bmm = '0; bmask = '0; mp = '0; tgt = '0;
  endtask

  task automatic drive(input int p, input logic [3:0] b, input logic [3:0] m,
                       input logic mis, input logic [31:0] t);
    v[p] = 1'b1; bmm[p] = b; bmask[p] = m; mp[p] = mis; tgt[p] = t;
  endtask

  // Queue what must appear after the next edge, then advance and compare.
  task automatic cycle(input string tag, input logic [3:0] res, input logic m,
                       input logic [31:0] t, input logic [3:0] pend);
    exp_t e;
    exp_q.push_back('{tag, res, m, t, pend});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (o_res === e.res) else begin
      errors++;
      $error("FAIL %s resolve got %b exp %b", e.tag, o_res, e.res);
    end
    checks++;
    assert (o_mp === e.mp) else begin
      errors++;
      $error("FAIL %s mispred got %b exp %b", e.tag, o_mp, e.mp);
    end
    checks++;
    assert (o_tgt === e.tgt) else begin
      errors++;
      $error("FAIL %s target got %h exp %h", e.tag, o_tgt, e.tgt);
    end
    checks++;
    assert (o_pend === e.pend) else begin
      errors++;
      $error("FAIL %s pending got %b exp %b", e.tag, o_pend, e.pend);
    end
    $display("cycle %-10s res=%b mp=%b tgt=%h pend=%b", e.tag, o_res, o_mp, o_tgt, o_pend);
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    cycle("rst0", 4'b0000, 1'b0, 32'h0, 4'b0000);
    drive(0, 4'b0001, 4'b0000, 1'b0, 32'h0AA);
    cycle("rst1", 4'b0000, 1'b0, 32'h0, 4'b0000);
    rst = 1'b0;
    clear_in();
    cycle("rstdisc", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Single correct completion
    drive(0, 4'b0010, 4'b0000, 1'b0, 32'h100);
    cycle("single", 4'b0010, 1'b0, 32'h100, 4'b0000);
    clear_in();
    cycle("single+2", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Two correct in one cycle, lower index first
    drive(0, 4'b0001, 4'b0000, 1'b0, 32'h200);
    drive(1, 4'b0100, 4'b0000, 1'b0, 32'h204);
    cycle("two_a", 4'b0001, 1'b0, 32'h200, 4'b0100);
    clear_in();
    cycle("two_b", 4'b0100, 1'b0, 32'h204, 4'b0000);
    cycle("two_idle", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Older mispredict wins, younger dependent mispredict dropped
    drive(0, 4'b0001, 4'b0000, 1'b1, 32'h300);
    drive(1, 4'b0100, 4'b0001, 1'b1, 32'h304);
    cycle("oldmp", 4'b0001, 1'b1, 32'h300, 4'b0100);
    clear_in();
    cycle("oldmp_drop", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Dependent of a mispredict is dropped
    drive(0, 4'b0010, 4'b0000, 1'b1, 32'h400);
    drive(1, 4'b1000, 4'b0010, 1'b0, 32'h404);
    cycle("dep_mp", 4'b0010, 1'b1, 32'h400, 4'b1000);
    clear_in();
    cycle("dep_mp_drop", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Dependent of a correct branch is untagged and broadcast next
    drive(0, 4'b0010, 4'b0000, 1'b0, 32'h410);
    drive(1, 4'b1000, 4'b0010, 1'b0, 32'h414);
    cycle("dep_ok", 4'b0010, 1'b0, 32'h410, 4'b1000);
    clear_in();
    cycle("dep_ok_nxt", 4'b1000, 1'b0, 32'h414, 4'b0000);
    cycle("dep_ok_idle", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Same-cycle arrival during a mispredict broadcast is filtered
    drive(0, 4'b0001, 4'b0000, 1'b1, 32'h500);
    cycle("arr_mp", 4'b0001, 1'b1, 32'h500, 4'b0000);
    clear_in();
    drive(0, 4'b0100, 4'b0001, 1'b0, 32'h504);
    cycle("arr_mp_drop", 4'b0000, 1'b0, 32'h0, 4'b0000);
    clear_in();
    cycle("arr_mp_idle", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Same-cycle arrival during a correct broadcast is untagged
    drive(0, 4'b0001, 4'b0000, 1'b0, 32'h510);
    cycle("arr_ok", 4'b0001, 1'b0, 32'h510, 4'b0000);
    clear_in();
    drive(0, 4'b0100, 4'b0001, 1'b0, 32'h514);
    cycle("arr_ok_nxt", 4'b0100, 1'b0, 32'h514, 4'b0000);
    clear_in();
    cycle("arr_ok_idle", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Mispredict outranks a lower-index correct entry that depends on it
    drive(0, 4'b0001, 4'b0100, 1'b0, 32'h600);
    drive(1, 4'b0100, 4'b0000, 1'b1, 32'h604);
    cycle("mp_prio", 4'b0100, 1'b1, 32'h604, 4'b0001);
    clear_in();
    cycle("mp_prio_drop", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Mispredict depending only on a correct branch goes first
    drive(0, 4'b0001, 4'b0000, 1'b0, 32'h700);
    drive(1, 4'b0010, 4'b0001, 1'b1, 32'h704);
    cycle("mp_first", 4'b0010, 1'b1, 32'h704, 4'b0001);
    clear_in();
    cycle("mp_then_ok", 4'b0001, 1'b0, 32'h700, 4'b0000);
    cycle("mp_idle", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Reset mid-operation with several slots held
    drive(0, 4'b0001, 4'b0000, 1'b0, 32'h800);
    drive(1, 4'b0010, 4'b0001, 1'b0, 32'h804);
    cycle("mid_a", 4'b0001, 1'b0, 32'h800, 4'b0010);
    clear_in();
    drive(0, 4'b0100, 4'b0000, 1'b0, 32'h808);
    drive(1, 4'b1000, 4'b0000, 1'b0, 32'h80C);
    cycle("mid_b", 4'b0010, 1'b0, 32'h804, 4'b1100);
    clear_in();
    rst = 1'b1;
    cycle("mid_rst", 4'b0000, 1'b0, 32'h0, 4'b0000);
    rst = 1'b0;
    cycle("post_rst0", 4'b0000, 1'b0, 32'h0, 4'b0000);
    cycle("post_rst1", 4'b0000, 1'b0, 32'h0, 4'b0000);
    drive(1, 4'b0100, 4'b0000, 1'b0, 32'h900);
    cycle("post_new", 4'b0100, 1'b0, 32'h900, 4'b0000);
    clear_in();
    cycle("post_idle", 4'b0000, 1'b0, 32'h0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter: NUM_BR_FU, 2, number of branch-completion ports accepted per cycle.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 br_cmpl_valid  input  NUM_BR_FU  per-port completion valid.
REQ-005 br_cmpl_b_mm  input  NUM_BR_FU x B_MASK_WIDTH  one-hot branch-stack slot of the completing branch.
REQ-006 br_cmpl_b_mask  input  NUM_BR_FU x B_MASK_WIDTH  unresolved older branches the completing branch depends on.
REQ-007 br_cmpl_mispred  input  NUM_BR_FU  1 = branch mispredicted.
REQ-008 br_cmpl_target  input  NUM_BR_FU x ADDR  resolved correct next PC.
REQ-009 b_mm_resolve  output  B_MASK_WIDTH  one-hot resolve broadcast to branch stack, RS, ROB, LSQ; zero = none.
REQ-010 b_mm_mispred  output  1  broadcast is a mispredict (meaningful only when b_mm_resolve != 0).
REQ-011 b_mm_target  output  ADDR  correct PC of broadcast branch.
REQ-012 pending_mask  output  B_MASK_WIDTH  slots currently held, debug/verification only.

Function
REQ-013 Pending table SHALL have one entry per branch-stack slot: valid, mispred, dep b_mask, target; index = position of the one-hot b_mm bit.
REQ-014 All outputs SHALL be registered; a completion arriving in cycle N is broadcast no earlier than cycle N+1.
REQ-015 At most one slot SHALL be broadcast per cycle; the broadcast entry is freed in the same posedge its output is registered.
REQ-016 Selection SHALL be: eligible mispredict = valid & mispred & (dep b_mask & pending-mispred vector) == 0; pick lowest-index eligible mispredict; otherwise the lowest-index valid correct entry whose dep b_mask has no pending-mispred bit; otherwise broadcast zero.
REQ-017 While b_mm_resolve = bit k is being output, pending entries and same-cycle arrivals SHALL have bit k cleared from their dep b_mask before being stored.
REQ-018 While a mispredict on bit k is being output, pending entries and same-cycle arrivals whose dep b_mask has bit k set SHALL be dropped.
REQ-019 An arrival whose own b_mm equals the bit currently broadcast is illegal; an arrival to an already-valid slot is illegal; both SHALL be flagged by assertion, not handled.
REQ-020 Arrivals and free of the broadcast slot in the same cycle SHALL both take effect; table never overflows (one slot per branch-stack entry), so no backpressure exists.
REQ-021 Arrivals on multiple ports in one cycle SHALL be stored in parallel; port order is irrelevant.
REQ-022 b_mm_target SHALL be zero whenever b_mm_resolve is zero.

Reset
REQ-023 On reset all pending entries SHALL be invalid and b_mm_resolve, b_mm_mispred, b_mm_target, pending_mask SHALL be 0 in the following cycle.
REQ-024 Reset SHALL override simultaneous arrivals; arrivals in the reset cycle are discarded.

Structure
REQ-025 BR_CMPL_PACKET typedef (valid, b_mm, b_mask, mispred, target) and NUM_BR_FU macro SHALL live in sys_defs.svh beside B_MASK, B_MASK_MASK, ADDR.
REQ-026 Selection logic SHALL be one combinational sub-module, br_resolve_select (pending vectors in, one-hot grant and mispred flag out).

Verification (B_MASK_WIDTH = 4)
REQ-027 Single correct: port0 b_mm=0010, mask=0000, mispred=0, target=0x100 at cycle N -> cycle N+1 b_mm_resolve=0010, mispred=0, target=0x100; cycle N+2 resolve=0000, pending_mask=0000.
REQ-028 Two correct same cycle: ports b_mm=0001 and 0100 -> N+1 broadcast 0001, N+2 broadcast 0100, N+1 pending_mask=0100.
REQ-029 Older mispredict wins: pending mispred 0001 (mask 0000) and mispred 0100 (mask 0001) -> broadcast 0001 mispred=1; next cycle 0100 dropped, resolve=0000, pending_mask=0000.
REQ-030 Dependency cleanup: pending correct 1000 mask 0010 while mispred 0010 broadcast -> 1000 dropped; same setup with 0010 correct -> 1000 stored with mask 0000 and broadcast next cycle.
REQ-031 Same-cycle arrival filtering: arrival b_mm=0100 mask=0001 during broadcast 0001 mispred -> never broadcast; during broadcast 0001 correct -> stored with mask 0000.
REQ-032 Reset mid-operation: three slots pending, assert reset one cycle -> next cycle all outputs 0, pending_mask=0000, no broadcast until new arrival.
